// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett modular reducer: din_a mod Q with valid/ready flow control
// and an 8-bit sideband tag carried alongside each operand.
module barrett_reduce_pipe #(
    parameter int Q    = 727,
    parameter int QW   = $clog2(Q),
    parameter int IN_W = 2*QW-1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] din_a,
    input  logic [7:0]      in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   dout_r,
    output logic [7:0]      out_tag
);

    localparam int HW = IN_W - QW + 1;   // width of din_a >> (QW-1)
    localparam int MW = QW + 2;          // MU < 2^(QW+1) always fits here
    localparam int PW = HW + MW;         // full q_hat product width
    localparam int RW = QW + 2;          // remainder width, holds values < 3Q

    localparam logic [63:0]   MU_FULL = (64'd1 << (2*QW)) / 64'(Q);
    localparam logic [MW-1:0] MU      = MU_FULL[MW-1:0];
    localparam logic [RW-1:0] Q_R     = RW'(Q);
    localparam logic [RW-1:0] Q2_R    = RW'(2*Q);

    logic            v1, v2, v3;
    logic [IN_W-1:0] a1;
    logic [PW-1:0]   qh1;
    logic [7:0]      t1, t2, t3;
    logic [RW-1:0]   r2;
    logic [QW-1:0]   r3;

    logic en1, en2, en3;

    // A stage may load when it is empty or its contents are leaving this cycle.
    assign en3 = !v3 || out_ready;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    assign in_ready  = !rst && en1;
    assign out_valid = v3;
    assign dout_r    = r3;
    assign out_tag   = t3;

    // S1: estimate of the quotient scaled by 2^(QW+1)
    logic [HW-1:0] a_hi;
    logic [PW-1:0] qh_next;

    assign a_hi    = din_a[IN_W-1:QW-1];
    assign qh_next = PW'(a_hi) * PW'(MU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            qh1 <= '0;
            t1  <= '0;
        end else if (en1) begin
            v1  <= in_valid;
            a1  <= din_a;
            qh1 <= qh_next;
            t1  <= in_tag;
        end
    end

    // S2: the true difference is below 3Q, so arithmetic modulo 2^RW is exact.
    logic [PW-1:0] q_shift;
    logic [RW-1:0] qq, a_lo, r_next;

    assign q_shift = qh1 >> (QW+1);
    assign qq      = q_shift[RW-1:0] * Q_R;
    assign a_lo    = RW'(a1);
    assign r_next  = a_lo - qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            r2 <= '0;
            t2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            r2 <= r_next;
            t2 <= t1;
        end
    end

    // S3: final correction, at most two subtractions of Q
    logic [RW-1:0] r_fix;

    always_comb begin
        r_fix = r2;
        if (r2 >= Q2_R)
            r_fix = r2 - Q2_R;
        else if (r2 >= Q_R)
            r_fix = r2 - Q_R;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3 <= 1'b0;
            r3 <= '0;
            t3 <= '0;
        end else if (en3) begin
            v3 <= v2;
            r3 <= r_fix[QW-1:0];
            t3 <= t2;
        end
    end

endmodule

// File: doc/barrett_reduce_pipe.md
BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

Interface
REQ-001 Parameter Q, default 727: odd modulus, 3 <= Q < 2^16.
REQ-002 Parameter QW, default $clog2(Q) = 10: residue width.
REQ-003 Parameter IN_W, default 2*QW-1 = 19: operand width; SHALL satisfy IN_W <= 2*QW.
REQ-004 Parameter MU, default floor(2^(2*QW)/Q) = 1442: Barrett constant, computed at elaboration and not overridable per-instance.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  din_a carries an operand this cycle.
REQ-008 in_ready  output  1  block accepts din_a this cycle.
REQ-009 din_a  input  IN_W  operand to reduce, unsigned.
REQ-010 in_tag  input  8  opaque sideband, returned unchanged with the result.
REQ-011 out_valid  output  1  dout_r/out_tag hold a result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 dout_r  output  QW  din_a mod Q.
REQ-014 out_tag  output  8  tag of the operand that produced dout_r.

Function
REQ-015 Transfer occurs on a rising edge with in_valid && in_ready (input) or out_valid && out_ready (output).
REQ-016 Pipeline SHALL have three register stages, S1 -> S2 -> S3; each stage holds a valid bit, data and tag.
REQ-017 S1 SHALL capture q_hat = (din_a >> (QW-1)) * MU at full product width, with no truncation.
REQ-018 S2 SHALL capture r = din_a - (q_hat >> (QW+1)) * Q, computed at width QW+2 (the true difference is < 3Q).
REQ-019 S3 SHALL capture r - 2Q if r >= 2Q, else r - Q if r >= Q, else r; dout_r SHALL be driven directly from S3.
REQ-020 Result SHALL equal din_a mod Q exactly for every din_a in [0, 2^IN_W - 1].
REQ-021 Latency SHALL be 3 cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be one operand per cycle.
REQ-022 Stall control: stage k advances when its downstream stage is empty or advancing; in_ready = !S1.valid || S1 advances.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 While out_valid && !out_ready, dout_r and out_tag SHALL hold stable.
- Upstream bubbles SHALL collapse, so at most 3 operands are in flight.
- No operand SHALL be dropped or duplicated.
REQ-024 Results SHALL emerge in acceptance order with their own tags.
REQ-025 Simultaneous input and output transfer in the same cycle with a full pipeline SHALL be accepted with no bubble.
REQ-026 Data and tag registers of an empty stage are don't-care internally; the dout_r/out_tag hold rule of REQ-023 still applies at the output.

Reset
REQ-027 On rst assertion, all stage valid bits SHALL clear immediately (asynchronously) and out_valid SHALL be 0.
REQ-028 While rst is asserted, dout_r and out_tag SHALL be 0 and in_ready SHALL be 0.
REQ-029 After rst deassertion, in_ready SHALL be 1 from the first clock edge.
REQ-030 Reset mid-operation SHALL discard all in-flight operands; none SHALL appear after reset.

Verification
REQ-031 Identity/boundary, out_ready=1: din_a 0, 726, 727, 1453, 1454, 524287 (tags 1..6) -> dout_r 0, 726, 0, 726, 0, 120 with tags 1..6, first result 3 cycles after first accept, then one per cycle.
REQ-032 Exhaustive: all 2^19 operands back-to-back with out_ready=1 -> every result equals din_a mod 727 and sustained throughput is 1/cycle.
REQ-033 Backpressure: stream 5 operands while out_ready=0 -> in_ready drops after 3 accepts and out_valid=1 with dout_r stable; raise out_ready -> 5 correct results in order, no loss.
REQ-034 Random in_valid/out_ready at 50% each over 10^5 operands -> scoreboard matches values and tags in order.
REQ-035 Reset mid-stream: assert rst with 3 operands in flight -> out_valid falls without waiting for a clock, no stale result after release, and the next operand 1000 returns 273.
REQ-036 Parameter sweep: Q = 3, 3329, 12289, 65521 with default derivations, 10^4 random operands each -> all results match the golden model.
